// File: rtl/alu_pkg.sv
// Shared ALU decode definitions: instruction field positions, alu_write
// encodings, ALU opcode constants and the decoded-instruction bundle.
package alu_pkg;
  // Instruction field positions
  localparam int CLS_HI   = 31;  // [31:30] instruction class, 2'b00 = ALU
  localparam int CLS_LO   = 30;
  localparam int COND_B   = 29;
  localparam int CONSTC_B = 28;
  localparam int OP_HI    = 27;
  localparam int OP_LO    = 25;
  localparam int FORM_B   = 24;
  localparam int VEC_HI   = 23;
  localparam int VEC_LO   = 22;
  localparam int LSEL_HI  = 23;
  localparam int LSEL_LO  = 20;
  localparam int CMP_HI   = 22;
  localparam int CMP_LO   = 20;
  localparam int CFG_HI   = 19;
  localparam int CFG_LO   = 16;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  // alu_write encodings {Y2,Y1}
  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_Y1   = 2'b01;
  localparam logic [1:0] WR_BOTH = 2'b11;

  localparam logic [1:0] CLS_ALU = 2'b00;

  // ALU opcode constants
  typedef enum logic [2:0] {
    ALU_OP_ADD   = 3'b000,
    ALU_OP_SUB   = 3'b001,
    ALU_OP_LOGIC = 3'b010,
    ALU_OP_SHIFT = 3'b011,
    ALU_OP_MUL   = 3'b100,
    ALU_OP_MIN   = 3'b101,
    ALU_OP_MAX   = 3'b110,
    ALU_OP_COPY  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic        invalid;
    logic        cond;
    logic        const_c;
    logic [2:0]  op;
    logic        form;
    logic [1:0]  vec;
    logic [3:0]  lsel;
    logic [3:0]  cfg;
    logic [2:0]  cmp;
    logic [15:0] imm;
    logic [1:0]  write;
    logic [3:0]  a, b, c, d, y1, y2;
  } alu_dec_t;
endpackage

// File: rtl/alu_instruction_decoder_if.sv
// Decoder bus: instruction word in, decoded ALU control fields out.
// master drives the instruction and samples the fields; slave is the decoder.
interface alu_instruction_decoder_if #(parameter int DATA_WIDTH = 32);
  logic [31:0]           instruction;
  logic                  invalid_instruction;
  logic                  invalid_seen;
  logic [2:0]            alu_op;
  logic [1:0]            alu_vec_perci;
  logic                  alu_form;
  logic [3:0]            alu_config;
  logic                  const_c;
  logic [DATA_WIDTH-1:0] constant;
  logic [1:0]            alu_write;
  logic [3:0]            alu_a_select, alu_b_select, alu_c_select, alu_d_select;
  logic [3:0]            alu_Y1_select, alu_Y2_select;
  logic [3:0]            logic_select;
  logic                  condition;
  logic [2:0]            compare_op;

  modport master (
    output instruction,
    input  invalid_instruction, invalid_seen, alu_op, alu_vec_perci, alu_form,
           alu_config, const_c, constant, alu_write, alu_a_select, alu_b_select,
           alu_c_select, alu_d_select, alu_Y1_select, alu_Y2_select,
           logic_select, condition, compare_op
  );
  modport slave (
    input  instruction,
    output invalid_instruction, invalid_seen, alu_op, alu_vec_perci, alu_form,
           alu_config, const_c, constant, alu_write, alu_a_select, alu_b_select,
           alu_c_select, alu_d_select, alu_Y1_select, alu_Y2_select,
           logic_select, condition, compare_op
  );
endinterface

// File: rtl/alu_operand_select.sv
// Operand/destination register selects and write enables.
// Ports: instruction (in), a/b/c/d/y1/y2 selects (out), write enables (out).
// Register form: four 4-bit register fields, both destinations written.
// Constant form: a from the config field, b from [11:8], only Y1 written.
module alu_operand_select
  import alu_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [3:0]  a, b, c, d, y1, y2,
  output logic [1:0]  write
);
  always_comb begin
    if (instruction[CONSTC_B]) begin
      a     = instruction[19:16];
      b     = instruction[11:8];
      c     = 4'h0;
      d     = 4'h0;
      write = WR_Y1;
    end else begin
      a     = instruction[15:12];
      b     = instruction[11:8];
      c     = instruction[7:4];
      d     = instruction[3:0];
      write = WR_BOTH;
    end
  end

  assign y1 = a;
  assign y2 = b;
endmodule

// File: rtl/alu_instruction_decoder.sv
// ALU instruction decoder.
// Ports: clk, rst_n (async active-low), dec (slave side of the decoder bus:
// instruction in, decoded ALU control fields and sticky invalid_seen out).
// Macro ALU_DECODE_REG_EN: when defined, every decode output is registered
// (one-cycle latency, reset to 0); otherwise decode is purely combinational.
module alu_instruction_decoder
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  alu_instruction_decoder_if.slave  dec
);
  alu_dec_t d_c, d_q;
  logic [1:0] sel_write;
  logic       seen_q;

  alu_operand_select u_opsel (
    .instruction (dec.instruction),
    .a (d_c.a), .b (d_c.b), .c (d_c.c), .d (d_c.d),
    .y1 (d_c.y1), .y2 (d_c.y2),
    .write (sel_write)
  );

  always_comb begin
    d_c.invalid = dec.instruction[CLS_HI:CLS_LO] != CLS_ALU;
    d_c.cond    = dec.instruction[COND_B];
    d_c.const_c = dec.instruction[CONSTC_B];
    d_c.op      = dec.instruction[OP_HI:OP_LO];
    d_c.form    = dec.instruction[FORM_B];
    d_c.vec     = dec.instruction[VEC_HI:VEC_LO];
    d_c.lsel    = dec.instruction[LSEL_HI:LSEL_LO];
    d_c.cfg     = dec.instruction[CFG_HI:CFG_LO];
    d_c.cmp     = d_c.cond ? dec.instruction[CMP_HI:CMP_LO] : 3'b000;
    d_c.imm     = dec.instruction[IMM_HI:IMM_LO];
    // Non-ALU words still decode, but must never write back.
    d_c.write   = d_c.invalid ? WR_NONE : sel_write;
  end

`ifdef ALU_DECODE_REG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) d_q <= '0;
    else        d_q <= d_c;
`else
  assign d_q = d_c;
`endif

  // Sticky flag follows the visible invalid output, so in registered
  // mode it sets one cycle after the invalid word was presented.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)         seen_q <= 1'b0;
    else if (d_q.invalid) seen_q <= 1'b1;

  assign dec.invalid_instruction = d_q.invalid;
  assign dec.invalid_seen        = seen_q;
  assign dec.alu_op              = d_q.op;
  assign dec.alu_vec_perci       = d_q.vec;
  assign dec.alu_form            = d_q.form;
  assign dec.alu_config          = d_q.cfg;
  assign dec.const_c             = d_q.const_c;
  assign dec.constant            = DATA_WIDTH'(d_q.imm);
  assign dec.alu_write           = d_q.write;
  assign dec.alu_a_select        = d_q.a;
  assign dec.alu_b_select        = d_q.b;
  assign dec.alu_c_select        = d_q.c;
  assign dec.alu_d_select        = d_q.d;
  assign dec.alu_Y1_select       = d_q.y1;
  assign dec.alu_Y2_select       = d_q.y2;
  assign dec.logic_select        = d_q.lsel;
  assign dec.condition           = d_q.cond;
  assign dec.compare_op          = d_q.cmp;
endmodule

// File: tb/tb_alu_instruction_decoder.sv
module tb_alu_instruction_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_instruction_decoder_if #(.DATA_WIDTH(32)) bus ();
  alu_instruction_decoder #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .dec(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        inv;
    logic        cond;
    logic        constc;
    logic [2:0]  op;
    logic        form;
    logic [1:0]  vec;
    logic [3:0]  lsel;
    logic [3:0]  cfg;
    logic [2:0]  cmp;
    logic [31:0] cnst;
    logic [1:0]  wr;
    logic [3:0]  a, b, c, d;
  } vec_t;

  vec_t tbl[8];

  task automatic apply(input logic [31:0] w);
    @(negedge clk);
    bus.instruction = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         instr          inv cnd cc op      frm vec    lsel    cfg     cmp     const         wr     a     b     c     d
    tbl[0] = '{32'h00801234, 0, 0, 0, 3'b000, 0, 2'b10, 4'b1000, 4'h0, 3'b000, 32'h1234, 2'b11, 4'h1, 4'h2, 4'h3, 4'h4};
    tbl[1] = '{32'h10810800, 0, 0, 1, 3'b000, 0, 2'b10, 4'b1000, 4'h1, 3'b000, 32'h0800, 2'b01, 4'h1, 4'h8, 4'h0, 4'h0};
    tbl[2] = '{32'h18511001, 0, 0, 1, 3'b100, 0, 2'b01, 4'b0101, 4'h1, 3'b000, 32'h1001, 2'b01, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[3] = '{32'h05301234, 0, 0, 0, 3'b010, 1, 2'b00, 4'b0011, 4'h0, 3'b000, 32'h1234, 2'b11, 4'h1, 4'h2, 4'h3, 4'h4};
    tbl[4] = '{32'h20301234, 0, 1, 0, 3'b000, 0, 2'b00, 4'b0011, 4'h0, 3'b011, 32'h1234, 2'b11, 4'h1, 4'h2, 4'h3, 4'h4};
    tbl[5] = '{32'h00301234, 0, 0, 0, 3'b000, 0, 2'b00, 4'b0011, 4'h0, 3'b000, 32'h1234, 2'b11, 4'h1, 4'h2, 4'h3, 4'h4};
    tbl[6] = '{32'hC0000000, 1, 0, 0, 3'b000, 0, 2'b00, 4'b0000, 4'h0, 3'b000, 32'h0000, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0};
    // invalid class 01 with const form and condition: fields still decode, no write
    tbl[7] = '{32'h7EF7ABCD, 1, 1, 1, 3'b111, 0, 2'b11, 4'b1111, 4'h7, 3'b111, 32'hABCD, 2'b00, 4'h7, 4'hB, 4'h0, 4'h0};

    bus.instruction = 32'h0;
    #12;
    chk("reset_seen", bus.invalid_seen, 1'b0);
`ifdef ALU_DECODE_REG_EN
    chk("reset_write", bus.alu_write, 2'b00);
    chk("reset_a", bus.alu_a_select, 4'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // sticky flag stays clear on valid words
    apply(32'h00801234);
    apply(32'h00801234);
    chk("seen_clear_valid", bus.invalid_seen, 1'b0);

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].instr);
      chk($sformatf("v%0d_invalid", i), bus.invalid_instruction, tbl[i].inv);
      chk($sformatf("v%0d_condition", i), bus.condition, tbl[i].cond);
      chk($sformatf("v%0d_const_c", i), bus.const_c, tbl[i].constc);
      chk($sformatf("v%0d_alu_op", i), bus.alu_op, tbl[i].op);
      chk($sformatf("v%0d_form", i), bus.alu_form, tbl[i].form);
      chk($sformatf("v%0d_vec", i), bus.alu_vec_perci, tbl[i].vec);
      chk($sformatf("v%0d_lsel", i), bus.logic_select, tbl[i].lsel);
      chk($sformatf("v%0d_config", i), bus.alu_config, tbl[i].cfg);
      chk($sformatf("v%0d_cmp", i), bus.compare_op, tbl[i].cmp);
      chk($sformatf("v%0d_constant", i), bus.constant, tbl[i].cnst);
      chk($sformatf("v%0d_write", i), bus.alu_write, tbl[i].wr);
      chk($sformatf("v%0d_a", i), bus.alu_a_select, tbl[i].a);
      chk($sformatf("v%0d_b", i), bus.alu_b_select, tbl[i].b);
      chk($sformatf("v%0d_c", i), bus.alu_c_select, tbl[i].c);
      chk($sformatf("v%0d_d", i), bus.alu_d_select, tbl[i].d);
      chk($sformatf("v%0d_y1", i), bus.alu_Y1_select, tbl[i].a);
      chk($sformatf("v%0d_y2", i), bus.alu_Y2_select, tbl[i].b);
    end

    // sticky after invalid, held across valid words, cleared async by reset
    apply(32'hC0000000);
    apply(32'h00801234);
    apply(32'h00801234);
    chk("seen_sticky", bus.invalid_seen, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("seen_async_clear", bus.invalid_seen, 1'b0);
`ifdef ALU_DECODE_REG_EN
    chk("async_clear_write", bus.alu_write, 2'b00);
`endif
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ALU_DECODE_REG_EN
    // reset asserted with an invalid word pending must discard it
    apply(32'h00801234);
    @(negedge clk);
    bus.instruction = 32'hC0000000;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("discard_invalid", bus.invalid_instruction, 1'b0);
    chk("discard_seen", bus.invalid_seen, 1'b0);
    @(negedge clk);
    bus.instruction = 32'h00801234;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_write", bus.alu_write, 2'b11);
    chk("release_seen", bus.invalid_seen, 1'b0);
`else
    // zero latency: outputs follow instruction without a clock edge
    @(negedge clk);
    bus.instruction = 32'h00000000;
    #1;
    bus.instruction = 32'h05301234;
    #1;
    chk("comb_op", bus.alu_op, 3'b010);
    chk("comb_a", bus.alu_a_select, 4'h1);
    bus.instruction = 32'h40000000;
    #1;
    chk("comb_invalid", bus.invalid_instruction, 1'b1);
    chk("comb_write", bus.alu_write, 2'b00);
    chk("comb_seen_pre_edge", bus.invalid_seen, 1'b0);
    @(posedge clk);
    #1;
    chk("comb_seen_edge", bus.invalid_seen, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_instruction_decoder.md
ALU_INSTRUCTION_DECODER -- requirements
Module: alu_instruction_decoder

Interface
REQ-001 The block SHALL have one parameter: DATA_WIDTH, default 32, width of the constant output.
REQ-002 clk  input  1  sole clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 instruction  input  32  instruction word.
REQ-005 invalid_instruction  output  1  word is not an ALU instruction.
REQ-006 invalid_seen  output  1  sticky: an invalid instruction was decoded since reset.
REQ-007 alu_op  output  3  ALU operation.
REQ-008 alu_vec_perci  output  2  vector precision.
REQ-009 alu_form  output  1  0 = arithmetic form, 1 = logic/copy form.
REQ-010 alu_config  output  4  ALU config nibble.
REQ-011 const_c  output  1  constant operand mode.
REQ-012 constant  output  DATA_WIDTH  zero-extended immediate.
REQ-013 alu_write  output  2  write enables {Y2,Y1}.
REQ-014 alu_a_select, alu_b_select, alu_c_select, alu_d_select  output  4 each  operand register selects.
REQ-015 alu_Y1_select, alu_Y2_select  output  4 each  destination register selects.
REQ-016 logic_select  output  4  logic-function truth table.
REQ-017 condition  output  1  compare/condition instruction.
REQ-018 compare_op  output  3  comparison code.

Function
REQ-019 invalid_instruction SHALL be 1 iff instruction[31:30] != 2'b00.
REQ-020 condition = instruction[29]; const_c = instruction[28]; alu_op = instruction[27:25]; alu_form = instruction[24].
REQ-021 alu_vec_perci = instruction[23:22]; logic_select = instruction[23:20]; alu_config = instruction[19:16].
REQ-022 compare_op = instruction[22:20] when condition = 1, else 3'b000.
REQ-023 constant = zero-extended instruction[15:0] in all modes.
REQ-024 const_c = 0: a/b/c/d selects = instruction[15:12]/[11:8]/[7:4]/[3:0]; alu_write = 2'b11.
REQ-025 const_c = 1: a = instruction[19:16], b = instruction[11:8], c = d = 4'h0; alu_write = 2'b01.
REQ-026 alu_Y1_select SHALL equal alu_a_select and alu_Y2_select SHALL equal alu_b_select.
REQ-027 When invalid_instruction = 1, alu_write SHALL be 2'b00; other fields decode unchanged.
REQ-028 Decode outputs SHALL be purely combinational from instruction (zero latency) unless REQ-032 applies.
REQ-029 invalid_seen SHALL set on any rising clk edge where invalid_instruction = 1 and hold until reset.

Reset
REQ-030 rst_n low SHALL asynchronously clear invalid_seen to 0 and all registered outputs (REQ-032) to 0; combinational outputs are unaffected.
REQ-031 Release of rst_n SHALL take effect at the next rising clk edge; reset asserted mid-stream SHALL discard any pending registered decode.

Configuration
REQ-032 With ALU_DECODE_REG_EN defined, all decode outputs SHALL be registered on rising clk (one-cycle latency, reset value 0); without it, outputs are combinational per REQ-028.

Structure
REQ-033 Field bit positions, alu_write encodings and the ALU opcode constants SHALL reside in a shared package alu_pkg.
REQ-034 An optional sub-module alu_operand_select SHALL implement REQ-024..REQ-026; all other logic sits in the top module.

Verification
REQ-035 instruction 32'h00801234 -> alu_op 000, vec_perci 10, form 0, config 0, const_c 0, constant 32'h1234, write 11, a..d = 1,2,3,4, Y1 = 1, Y2 = 2.
REQ-036 instruction 32'h10810800 -> alu_op 000, vec_perci 10, const_c 1, constant 32'h0800, write 01, a = 1, b = 8, c = d = 0, Y1 = 1, Y2 = 8.
REQ-037 instruction 32'h18511001 -> alu_op 100, vec_perci 01, form 0, config 1, const_c 1, constant 32'h1001, write 01, a = 1, Y1 = 1.
REQ-038 instruction 32'h05301234 -> alu_op 010, form 1, logic_select 0011, a..d = 1,2,3,4, Y1 = 1, Y2 = 2.
REQ-039 instruction 32'hC0000000 -> invalid_instruction 1, write 00; after a clk edge invalid_seen 1; drive rst_n low -> invalid_seen 0 immediately.
REQ-040 instruction 32'h20301234 -> condition 1, compare_op 011; 32'h00301234 -> compare_op 000.
